// File: rtl/ascon_serial_io.sv
// Purpose : bit-serial loader/unloader around the ASCON AEAD core (load -> run -> gap -> unload).
// Latency : start pulse 1 cycle after accepted start edge; first output bit GAP cycles after ready_so rises.
// Backpr. : none; load_en is honoured only in IDLE/LOAD, start only once a full MAX_W-bit frame is loaded.
//
// Ports: clk/rst_n (async active-low); key_si/nonce_si/ad_si/data_si serial fields (MSB first, shifted
// on load_en); start_i level (rising edge = request); decrypt_i mode; core_* parallel fields, start pulse
// and result inputs; data_so/tag_so serial results (LSB first); ready_so, busy_o, auth_fail_o status.
// Optional feature: define ASCON_SIO_TAGCHK_EN to suppress decrypted text and flag auth_fail_o when the
// core reports a tag mismatch.
module ascon_serial_io #(
    parameter int KEY_W   = 128,
    parameter int NONCE_W = 128,
    parameter int AD_W    = 40,
    parameter int DATA_W  = 104,
    parameter int TAG_W   = 128,
    parameter int GAP     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_si,
    input  logic              nonce_si,
    input  logic              ad_si,
    input  logic              data_si,
    input  logic              load_en,
    input  logic              start_i,
    input  logic              decrypt_i,
    output logic [KEY_W-1:0]   core_key_o,
    output logic [NONCE_W-1:0] core_nonce_o,
    output logic [AD_W-1:0]    core_ad_o,
    output logic [DATA_W-1:0]  core_data_o,
    output logic              core_start_o,
    output logic              core_decrypt_o,
    input  logic              core_done_i,
    input  logic [DATA_W-1:0]  core_data_i,
    input  logic [TAG_W-1:0]   core_tag_i,
    input  logic              core_tag_ok_i,
    output logic              data_so,
    output logic              tag_so,
    output logic              ready_so,
    output logic              busy_o,
    output logic              auth_fail_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_W = max2(max2(max2(KEY_W, NONCE_W), max2(AD_W, DATA_W)), TAG_W);
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] MAX_L   = CW'(MAX_W);
    localparam logic [CW-1:0] KEY_L   = CW'(KEY_W);
    localparam logic [CW-1:0] NONCE_L = CW'(NONCE_W);
    localparam logic [CW-1:0] AD_L    = CW'(AD_W);
    localparam logic [CW-1:0] DATA_L  = CW'(DATA_W);
    localparam logic [3:0]    GAP_L   = 4'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP_WAIT, S_UNLOAD} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;      // bits loaded in LOAD, bits emitted in UNLOAD
    logic [3:0]          gap_cnt;
    logic                start_q;
    logic                start_pulse_q;
    logic                decrypt_q;
    logic                ready_q;
    logic                dso_q;
    logic                tso_q;
    logic                fail_q;
    logic [KEY_W-1:0]    key_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [AD_W-1:0]     ad_q;
    logic [DATA_W-1:0]   data_q;
    logic [MAX_W-1:0]    txt_sr;   // zero-extended so bits past the field width unload as 0
    logic [MAX_W-1:0]    tag_sr;

    logic start_edge;
    logic full;
    logic shift_en;
    logic tag_bad;

    assign start_edge = start_i & ~start_q;
    assign full       = (cnt == MAX_L);
    // cnt is 0 in IDLE, so every field takes the first bit there
    assign shift_en   = load_en && ((state == S_IDLE) || ((state == S_LOAD) && !full));

`ifdef ASCON_SIO_TAGCHK_EN
    assign tag_bad = decrypt_q & ~core_tag_ok_i;
`else
    logic unused_tag_ok;
    assign unused_tag_ok = core_tag_ok_i;
    assign tag_bad       = 1'b0;
`endif

    // Each field only takes the first <width> bits of the frame, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            data_q  <= '0;
        end else if (shift_en) begin
            if (cnt < KEY_L)   key_q   <= {key_q[KEY_W-2:0], key_si};
            if (cnt < NONCE_L) nonce_q <= {nonce_q[NONCE_W-2:0], nonce_si};
            if (cnt < AD_L)    ad_q    <= {ad_q[AD_W-2:0], ad_si};
            if (cnt < DATA_L)  data_q  <= {data_q[DATA_W-2:0], data_si};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            gap_cnt       <= '0;
            start_q       <= 1'b0;
            start_pulse_q <= 1'b0;
            decrypt_q     <= 1'b0;
            ready_q       <= 1'b0;
            dso_q         <= 1'b0;
            tso_q         <= 1'b0;
            fail_q        <= 1'b0;
            txt_sr        <= '0;
            tag_sr        <= '0;
        end else begin
            // edge detector always follows start_i so a held level cannot retrigger later
            start_q       <= start_i;
            start_pulse_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        cnt   <= CW'(1);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // a load cycle always beats a coincident start edge
                    if (load_en) begin
                        if (!full) cnt <= cnt + CW'(1);
                    end else if (full && start_edge) begin
                        decrypt_q     <= decrypt_i;
                        start_pulse_q <= 1'b1;
                        state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (core_done_i) begin
                        txt_sr  <= tag_bad ? '0 : MAX_W'(core_data_i);
                        tag_sr  <= MAX_W'(core_tag_i);
                        fail_q  <= tag_bad;
                        ready_q <= 1'b1;
                        gap_cnt <= '0;
                        state   <= S_GAP_WAIT;
                    end
                end
                S_GAP_WAIT: begin
                    // registering bit 0 on the GAP-th edge makes it visible GAP cycles after ready_so
                    if (gap_cnt == GAP_L) begin
                        dso_q  <= txt_sr[0];
                        tso_q  <= tag_sr[0];
                        txt_sr <= txt_sr >> 1;
                        tag_sr <= tag_sr >> 1;
                        cnt    <= CW'(1);
                        state  <= S_UNLOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_UNLOAD: begin
                    if (cnt == MAX_L) begin
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        dso_q   <= 1'b0;
                        tso_q   <= 1'b0;
                        fail_q  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        dso_q  <= txt_sr[0];
                        tso_q  <= tag_sr[0];
                        txt_sr <= txt_sr >> 1;
                        tag_sr <= tag_sr >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core_key_o     = key_q;
    assign core_nonce_o   = nonce_q;
    assign core_ad_o      = ad_q;
    assign core_data_o    = data_q;
    assign core_start_o   = start_pulse_q;
    assign core_decrypt_o = decrypt_q;
    assign data_so        = dso_q;
    assign tag_so         = tso_q;
    assign ready_so       = ready_q;
    assign busy_o         = (state != S_IDLE);
    assign auth_fail_o    = fail_q;

endmodule

// File: tb/tb_ascon_serial_io.sv
// Purpose : directed + randomized bench for ascon_serial_io with a frame-level reference model.
// Latency : expectations derived from frame contents and cycle counts (start +1, first bit +GAP).
// Backpr. : none exercised; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_ascon_serial_io;

    localparam int KEY_W = 128, NONCE_W = 128, AD_W = 40, DATA_W = 104, TAG_W = 128, GAP = 4;
    localparam int MAX_W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_si = 0, nonce_si = 0, ad_si = 0, data_si = 0, load_en = 0, start_i = 0, decrypt_i = 0;
    logic [KEY_W-1:0]   core_key_o;
    logic [NONCE_W-1:0] core_nonce_o;
    logic [AD_W-1:0]    core_ad_o;
    logic [DATA_W-1:0]  core_data_o;
    logic core_start_o, core_decrypt_o;
    logic core_done_i = 0;
    logic [DATA_W-1:0]  core_data_i = '0;
    logic [TAG_W-1:0]   core_tag_i = '0;
    logic core_tag_ok_i = 0;
    logic data_so, tag_so, ready_so, busy_o, auth_fail_o;

    ascon_serial_io #(.KEY_W(KEY_W), .NONCE_W(NONCE_W), .AD_W(AD_W), .DATA_W(DATA_W),
                      .TAG_W(TAG_W), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_si(key_si), .nonce_si(nonce_si), .ad_si(ad_si), .data_si(data_si),
        .load_en(load_en), .start_i(start_i), .decrypt_i(decrypt_i),
        .core_key_o(core_key_o), .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o),
        .core_data_o(core_data_o), .core_start_o(core_start_o), .core_decrypt_o(core_decrypt_o),
        .core_done_i(core_done_i), .core_data_i(core_data_i), .core_tag_i(core_tag_i),
        .core_tag_ok_i(core_tag_ok_i),
        .data_so(data_so), .tag_so(tag_so), .ready_so(ready_so), .busy_o(busy_o),
        .auth_fail_o(auth_fail_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int fails = 0;

    // current frame (reference model state)
    logic [KEY_W-1:0]   f_key;
    logic [NONCE_W-1:0] f_nonce;
    logic [AD_W-1:0]    f_ad;
    logic [DATA_W-1:0]  f_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame;
        f_key   = {$urandom, $urandom, $urandom, $urandom};
        f_nonce = {$urandom, $urandom, $urandom, $urandom};
        f_ad    = {8'($urandom), $urandom};
        f_data  = {8'($urandom), $urandom, $urandom, $urandom};
    endtask

    // Serial stream bit i carries field[W-1-i] for i < W; later bits are junk the DUT must ignore.
    task automatic load_bits(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            key_si   = (i < KEY_W)   ? f_key[KEY_W-1-i]     : 1'($urandom);
            nonce_si = (i < NONCE_W) ? f_nonce[NONCE_W-1-i] : 1'($urandom);
            ad_si    = (i < AD_W)    ? f_ad[AD_W-1-i]       : 1'($urandom);
            data_si  = (i < DATA_W)  ? f_data[DATA_W-1-i]   : 1'($urandom);
            load_en  = 1'b1;
            tick;
            load_en  = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) tick;
        end
    endtask

    task automatic pulse_start(input string tag, input logic expect_go, input logic dec);
        decrypt_i = dec;
        start_i   = 1'b1;
        tick;
        decrypt_i = ~dec;
        chk({tag, "_start"}, 128'(core_start_o), 128'(expect_go));
        tick;
        chk({tag, "_start_1cyc"}, 128'(core_start_o), 128'(0));
        start_i = 1'b0;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_key"},   128'(core_key_o),   128'(f_key));
        chk({tag, "_nonce"}, 128'(core_nonce_o), 128'(f_nonce));
        chk({tag, "_ad"},    128'(core_ad_o),    128'(f_ad));
        chk({tag, "_data"},  128'(core_data_o),  128'(f_data));
    endtask

    // Plays the core: done pulse with result, then collects the serial unload and compares
    // the reassembled words. stop_at >= 0 abandons the unload when that bit is on the pins.
    task automatic finish_txn(input string tag, input logic ok, input logic [DATA_W-1:0] txt,
                              input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] exp_txt,
                              input logic exp_fail, input int stop_at);
        logic [MAX_W-1:0] got_d, got_t;
        logic rdy_all;
        repeat ($urandom_range(1, 6)) tick;
        chk({tag, "_ready_run"}, 128'(ready_so), 128'(0));
        core_data_i   = txt;
        core_tag_i    = tg;
        core_tag_ok_i = ok;
        core_done_i   = 1'b1;
        tick;
        core_done_i   = 1'b0;
        core_data_i   = {8'($urandom), $urandom, $urandom, $urandom};
        core_tag_i    = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_ready_rise"}, 128'(ready_so), 128'(1));
        chk({tag, "_auth_fail"}, 128'(auth_fail_o), 128'(exp_fail));
        repeat (GAP) tick;
        got_d = '0;
        got_t = '0;
        rdy_all = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == stop_at) return;
            got_d[i] = data_so;
            got_t[i] = tag_so;
            rdy_all  = rdy_all & ready_so;
            tick;
        end
        chk({tag, "_text"}, 128'(got_d[DATA_W-1:0]), 128'(exp_txt));
        chk({tag, "_text_tail0"}, 128'(got_d[MAX_W-1:DATA_W]), 128'(0));
        chk({tag, "_tag"}, 128'(got_t), 128'(tg));
        chk({tag, "_ready_held"}, 128'(rdy_all), 128'(1));
        chk({tag, "_ready_fall"}, 128'(ready_so), 128'(0));
        chk({tag, "_busy_fall"}, 128'(busy_o), 128'(0));
        chk({tag, "_fail_clr"}, 128'(auth_fail_o), 128'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key"}, 128'(core_key_o), 128'(0));
        chk({tag, "_data"}, 128'(core_data_o), 128'(0));
        chk({tag, "_status"},
            128'({core_start_o, core_decrypt_o, data_so, tag_so, ready_so, busy_o, auth_fail_o}),
            128'(0));
    endtask

    logic [DATA_W-1:0] pt, ct;
    logic [TAG_W-1:0]  tg;
    logic              exp_fail;
    logic [DATA_W-1:0] exp_txt;

    initial begin
        repeat (3) tick;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick;

        // done pulse while idle must be ignored
        core_done_i = 1'b1;
        tick;
        core_done_i = 1'b0;
        tick;
        chk("idle_done_ready", 128'(ready_so), 128'(0));
        chk("idle_busy", 128'(busy_o), 128'(0));

        // known-answer encrypt frame
        f_key   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
        f_nonce = 128'h05885e606e1271b8d47a74c7b297a318;
        f_ad    = 40'h4153434f4e;
        f_data  = 104'h6173636f6e2d756e6963617373;
        ct      = 104'h18490112f8d5867a830748390b;
        tg      = {$urandom, $urandom, $urandom, $urandom};
        load_bits(0, MAX_W, 1'b0);
        chk("enc_busy", 128'(busy_o), 128'(1));
        pulse_start("enc", 1'b1, 1'b0);
        chk_fields("enc");
        chk("enc_decrypt", 128'(core_decrypt_o), 128'(0));
        finish_txn("enc", 1'b1, ct, tg, ct, 1'b0, -1);

        // start after a partial frame is ignored; completed frame is accepted
        rand_frame();
        load_bits(0, 100, 1'b1);
        pulse_start("partial", 1'b0, 1'b0);
        chk("partial_busy", 128'(busy_o), 128'(1));
        load_bits(100, MAX_W, 1'b1);
        pulse_start("partial_done", 1'b1, 1'b0);
        chk_fields("partial_done");
        ct = {8'($urandom), $urandom, $urandom, $urandom};
        tg = {$urandom, $urandom, $urandom, $urandom};
        finish_txn("partial_txn", 1'b1, ct, tg, ct, 1'b0, -1);

        // decrypt with a bad tag, then with a good tag
        for (int k = 0; k < 2; k++) begin
            rand_frame();
            pt = {8'($urandom), $urandom, $urandom, $urandom};
            if (k == 0) pt = 104'h6173636f6e2d756e6963617373;
            tg = {$urandom, $urandom, $urandom, $urandom};
            load_bits(0, MAX_W, 1'b1);
            pulse_start("dec", 1'b1, 1'b1);
            chk("dec_mode", 128'(core_decrypt_o), 128'(1));
            exp_txt  = pt;
            exp_fail = 1'b0;
`ifdef ASCON_SIO_TAGCHK_EN
            if (k == 0) begin
                exp_txt  = '0;
                exp_fail = 1'b1;
            end
`endif
            finish_txn((k == 0) ? "dec_badtag" : "dec_goodtag", (k == 0) ? 1'b0 : 1'b1,
                       pt, tg, exp_txt, exp_fail, -1);
        end

        // reset in the middle of unload, then start without reload is ignored
        rand_frame();
        load_bits(0, MAX_W, 1'b0);
        pulse_start("rst", 1'b1, 1'b0);
        ct = {8'($urandom), $urandom, $urandom, $urandom};
        tg = {$urandom, $urandom, $urandom, $urandom};
        finish_txn("rst", 1'b1, ct, tg, ct, 1'b0, 50);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        #2;
        rst_n = 1'b1;
        tick;
        pulse_start("rst_noload", 1'b0, 1'b0);
        chk("rst_noload_busy", 128'(busy_o), 128'(0));
        rand_frame();
        load_bits(0, MAX_W, 1'b1);
        pulse_start("rst_reload", 1'b1, 1'b0);
        chk_fields("rst_reload");
        ct = {8'($urandom), $urandom, $urandom, $urandom};
        tg = {$urandom, $urandom, $urandom, $urandom};
        finish_txn("rst_reload", 1'b1, ct, tg, ct, 1'b0, -1);

        // final load bit coincides with start edge: load wins, held start never retriggers
        rand_frame();
        load_bits(0, MAX_W - 1, 1'b0);
        key_si   = f_key[0];
        nonce_si = f_nonce[0];
        ad_si    = 1'($urandom);
        data_si  = 1'($urandom);
        load_en  = 1'b1;
        start_i  = 1'b1;
        tick;
        load_en  = 1'b0;
        chk("coinc_start", 128'(core_start_o), 128'(0));
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("coinc_held", 128'(core_start_o), 128'(0));
        end
        chk("coinc_busy", 128'(busy_o), 128'(1));
        chk_fields("coinc");
        start_i = 1'b0;
        tick;
        pulse_start("coinc_retry", 1'b1, 1'b0);
        ct = {8'($urandom), $urandom, $urandom, $urandom};
        tg = {$urandom, $urandom, $urandom, $urandom};
        finish_txn("coinc_txn", 1'b1, ct, tg, ct, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
